set_assoc: RTL and testbench
============================

SET_ASSOC -- requirements
Module: set_assoc

Interface
REQ-001 Parameters SHALL be: WAYS, default 2, associativity (power of 2, 1..8); WORDS, default 4, words per line (power of 2); TAG_W, default 5, tag width; DATA_W, default 16, data word width.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 enable  in  1  operation request, level; a new operation starts only from IDLE.
REQ-005 comp  in  1  1 = compare (tag lookup) operation, 0 = access (direct way) operation.
REQ-006 write  in  1  1 = write operation, 0 = read operation.
REQ-007 word  in  log2(WORDS)  word index within the line.
REQ-008 way_sel  in  log2(WAYS) (min 1)  target way for access operations.
REQ-009 tag_in  in  TAG_W  tag for compare, or tag to install on access write.
REQ-010 data_in  in  DATA_W  write data.
REQ-011 valid_in  in  1  valid bit installed on access write.
REQ-012 hit  out  1  compare tag match on a valid way.
REQ-013 hit_way  out  log2(WAYS)  way that hit; 0 when hit=0.
REQ-014 valid_out, dirty_out  out  1 each  status of the reported way.
REQ-015 tag_out  out  TAG_W  tag of the reported way.
REQ-016 data_out  out  DATA_W  read data.
REQ-017 ack  out  1  one-cycle completion pulse.

Function
REQ-018 FSM states SHALL be IDLE, LOOKUP, RESP, WAIT_LOW: IDLE->LOOKUP when enable=1 (inputs captured); LOOKUP->RESP always; RESP->WAIT_LOW always; WAIT_LOW->IDLE when enable=0.
REQ-019 ack SHALL be 1 exactly during RESP, giving 2 cycles from the capture edge to ack; outputs SHALL hold until the next operation's RESP.
REQ-020 Compare read: tag match on a valid way SHALL give hit=1, hit_way=that way, data_out=word of that way, status of that way; on a miss, hit=0 and status/tag_out of way_sel, data_out unchanged.
REQ-021 Compare write: a hit SHALL write data_in to the word, set that way's dirty=1, and report hit=1, dirty_out=1; a miss SHALL write nothing and report hit=0 with way_sel status.
REQ-022 Access read SHALL return tag_out, valid_out, dirty_out, and data_out of way_sel/word, with hit=0.
REQ-023 Access write SHALL install tag_in, valid_in, dirty=0 and data_in at word in way_sel; the other words of that line are unchanged.
REQ-024 Multiple valid ways matching the tag SHALL resolve to the lowest-numbered way.
REQ-025 Input changes outside IDLE SHALL be ignored; enable held high after ack SHALL NOT start a second operation.
REQ-026 A tag match on an invalid way SHALL be a miss.

Reset
REQ-027 rst=1 SHALL force IDLE and clear all valid and dirty bits; tag and data storage are not cleared.
REQ-028 On reset all outputs SHALL be 0; rst mid-operation SHALL abort the operation with no ack and no storage write.

Configuration
REQ-029 With SET_LRU_EN defined, the block SHALL keep a per-way age, update it on every hit or access, and add output victim (log2(WAYS)) giving the least-recently-used way (an invalid way, lowest index, takes precedence); without SET_LRU_EN, the port and the logic SHALL be absent.

Structure
REQ-030 Package set_pkg SHALL hold the FSM state enum and an op enum {CMP_RD, CMP_WR, ACC_RD, ACC_WR}.
REQ-031 Per-way storage SHALL be sub-module way_store (tag, valid, dirty, WORDS×DATA_W words, one write port, one read port), instantiated WAYS times.

Verification
REQ-032 Reset, then access write way1 tag=0x0A word2 data=0xBEEF valid=1 -> ack exactly 2 cycles after the capture edge; access read way1 word2 returns 0xBEEF, tag_out=0x0A, dirty_out=0.
REQ-033 Compare read tag=0x0A word2 -> hit=1, hit_way=1, data_out=0xBEEF; tag=0x0B -> hit=0.
REQ-034 Compare write tag=0x0A word2 data=0x1234 -> hit=1, dirty_out=1; a following access read returns 0x1234.
REQ-035 Hold enable high for 6 cycles -> exactly one ack; assert rst in LOOKUP -> no ack, and a following compare read misses.
REQ-036 SET_LRU_EN defined, WAYS=2: fill way0 then way1, compare-read way0 -> victim=1.

Source files
------------

// File: rtl/set_pkg.sv
// Shared types for the set-associative cache block: controller states and decoded operations.
package set_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOOKUP   = 2'd1,
    RESP     = 2'd2,
    WAIT_LOW = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CMP_RD = 2'd0,
    CMP_WR = 2'd1,
    ACC_RD = 2'd2,
    ACC_WR = 2'd3
  } op_t;

  function automatic op_t op_decode(input logic comp, input logic write);
    case ({comp, write})
      2'b10:   op_decode = CMP_RD;
      2'b11:   op_decode = CMP_WR;
      2'b01:   op_decode = ACC_WR;
      default: op_decode = ACC_RD;
    endcase
  endfunction

endpackage

// File: rtl/way_store.sv
// Storage for one way: tag, valid, dirty and a line of WORDS data words.
// One write port (install or dirty-marking data write) and one combinational read port.
module way_store #(
  parameter  int WORDS  = 4,
  parameter  int TAG_W  = 5,
  parameter  int DATA_W = 16,
  localparam int WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_install,
  input  logic              i_mark_dirty,
  input  logic [WORD_W-1:0] i_word,
  input  logic [TAG_W-1:0]  i_tag,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic [TAG_W-1:0]  o_tag,
  output logic              o_valid,
  output logic              o_dirty,
  output logic [DATA_W-1:0] o_rdata
);

  logic [TAG_W-1:0]  r_tag;
  logic              r_valid;
  logic              r_dirty;
  logic [DATA_W-1:0] r_mem [WORDS];

  // Only status bits are reset; tag and data keep whatever they held.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_dirty <= 1'b0;
    end else if (i_install) begin
      r_valid <= i_valid;
      r_dirty <= 1'b0;
    end else if (i_mark_dirty) begin
      r_dirty <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_install) begin
      r_tag <= i_tag;
    end
    if (i_install || i_mark_dirty) begin
      r_mem[i_word] <= i_data;
    end
  end

  assign o_tag   = r_tag;
  assign o_valid = r_valid;
  assign o_dirty = r_dirty;
  assign o_rdata = r_mem[i_word];

endmodule

// File: rtl/set_assoc.sv
// Set-associative line controller: compare (tag lookup) and access (direct way) operations.
// Optional LRU victim tracking is built when SET_LRU_EN is defined.
module set_assoc
  import set_pkg::*;
#(
  parameter  int WAYS   = 2,
  parameter  int WORDS  = 4,
  parameter  int TAG_W  = 5,
  parameter  int DATA_W = 16,
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              comp,
  input  logic              write,
  input  logic [WORD_W-1:0] word,
  input  logic [WAY_W-1:0]  way_sel,
  input  logic [TAG_W-1:0]  tag_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              hit,
  output logic [WAY_W-1:0]  hit_way,
  output logic              valid_out,
  output logic              dirty_out,
  output logic [TAG_W-1:0]  tag_out,
  output logic [DATA_W-1:0] data_out,
  output logic              ack,
  output logic [1:0]        dbg_state
`ifdef SET_LRU_EN
  ,
  output logic [WAY_W-1:0]  victim
`endif
);

  // Handshake: enable is a level request sampled only in IDLE; ack pulses for one
  // cycle in RESP; the block returns to IDLE only after enable has been dropped.

  state_t            r_state;
  op_t               r_op;
  logic [WORD_W-1:0] r_word;
  logic [WAY_W-1:0]  r_way;
  logic [TAG_W-1:0]  r_tag;
  logic [DATA_W-1:0] r_data;
  logic              r_valid_in;

  logic              r_hit;
  logic [WAY_W-1:0]  r_hit_way;
  logic              r_valid_out;
  logic              r_dirty_out;
  logic [TAG_W-1:0]  r_tag_out;
  logic [DATA_W-1:0] r_data_out;
  logic              r_ack;

  logic [TAG_W-1:0]  w_tag   [WAYS];
  logic              w_valid [WAYS];
  logic              w_dirty [WAYS];
  logic [DATA_W-1:0] w_rdata [WAYS];

  logic              w_go;
  logic              w_is_acc;
  logic              w_hit;
  logic [WAY_W-1:0]  w_hit_way;
  logic [WAY_W-1:0]  w_rep_way;

  assign w_go     = (r_state == LOOKUP) && !rst;
  assign w_is_acc = (r_op == ACC_RD) || (r_op == ACC_WR);

  // Descending scan so the lowest-numbered matching way wins.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (w_valid[i] && (w_tag[i] == r_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(i);
      end
    end
  end

  assign w_rep_way = (!w_is_acc && w_hit) ? w_hit_way : r_way;

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    logic w_install;
    logic w_mark_dirty;

    assign w_install    = w_go && (r_op == ACC_WR) && (r_way == WAY_W'(g));
    assign w_mark_dirty = w_go && (r_op == CMP_WR) && w_hit && (w_hit_way == WAY_W'(g));

    way_store #(
      .WORDS  (WORDS),
      .TAG_W  (TAG_W),
      .DATA_W (DATA_W)
    ) u_way (
      .clk          (clk),
      .rst          (rst),
      .i_install    (w_install),
      .i_mark_dirty (w_mark_dirty),
      .i_word       (r_word),
      .i_tag        (r_tag),
      .i_valid      (r_valid_in),
      .i_data       (r_data),
      .o_tag        (w_tag[g]),
      .o_valid      (w_valid[g]),
      .o_dirty      (w_dirty[g]),
      .o_rdata      (w_rdata[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_op        <= CMP_RD;
      r_word      <= '0;
      r_way       <= '0;
      r_tag       <= '0;
      r_data      <= '0;
      r_valid_in  <= 1'b0;
      r_hit       <= 1'b0;
      r_hit_way   <= '0;
      r_valid_out <= 1'b0;
      r_dirty_out <= 1'b0;
      r_tag_out   <= '0;
      r_data_out  <= '0;
      r_ack       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (enable) begin
            r_op       <= op_decode(comp, write);
            r_word     <= word;
            r_way      <= way_sel;
            r_tag      <= tag_in;
            r_data     <= data_in;
            r_valid_in <= valid_in;
            r_state    <= LOOKUP;
          end
        end
        LOOKUP: begin
          r_state   <= RESP;
          r_ack     <= 1'b1;
          r_hit     <= !w_is_acc && w_hit;
          r_hit_way <= (!w_is_acc && w_hit) ? w_hit_way : '0;
          if (r_op == ACC_WR) begin
            r_tag_out   <= r_tag;
            r_valid_out <= r_valid_in;
            r_dirty_out <= 1'b0;
            r_data_out  <= r_data;
          end else begin
            r_tag_out   <= w_tag[w_rep_way];
            r_valid_out <= w_valid[w_rep_way];
            r_dirty_out <= w_dirty[w_rep_way] | ((r_op == CMP_WR) && w_hit);
            // A compare miss leaves the previous read data in place.
            if (w_is_acc || w_hit) begin
              r_data_out <= (r_op == CMP_WR) ? r_data : w_rdata[w_rep_way];
            end
          end
        end
        RESP: begin
          r_ack   <= 1'b0;
          r_state <= WAIT_LOW;
        end
        WAIT_LOW: begin
          if (!enable) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign hit       = r_hit;
  assign hit_way   = r_hit_way;
  assign valid_out = r_valid_out;
  assign dirty_out = r_dirty_out;
  assign tag_out   = r_tag_out;
  assign data_out  = r_data_out;
  assign ack       = r_ack;
  assign dbg_state = r_state;

`ifdef SET_LRU_EN
  // Age 0 is most recent; the touched way goes to 0 and younger ways age by one.
  logic [WAY_W-1:0] r_age [WAYS];
  logic [WAY_W-1:0] w_old_age;
  logic             w_any_inv;
  logic [WAY_W-1:0] w_inv_way;
  logic [WAY_W-1:0] w_old_way;
  logic [WAY_W-1:0] w_best_age;

  assign w_old_age = r_age[w_rep_way];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WAYS; i++) begin
        r_age[i] <= WAY_W'(i);
      end
    end else if (w_go && (w_is_acc || w_hit)) begin
      for (int i = 0; i < WAYS; i++) begin
        if (WAY_W'(i) == w_rep_way) begin
          r_age[i] <= '0;
        end else if (r_age[i] < w_old_age) begin
          r_age[i] <= r_age[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_any_inv  = 1'b0;
    w_inv_way  = '0;
    w_old_way  = '0;
    w_best_age = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!w_valid[i]) begin
        w_any_inv = 1'b1;
        w_inv_way = WAY_W'(i);
      end
    end
    for (int i = 0; i < WAYS; i++) begin
      if (r_age[i] > w_best_age) begin
        w_best_age = r_age[i];
        w_old_way  = WAY_W'(i);
      end
    end
  end

  assign victim = w_any_inv ? w_inv_way : w_old_way;
`endif

endmodule

// File: tb/tb_set_assoc.sv
// Directed bench for set_assoc (default parameters); adds the victim check when SET_LRU_EN is defined.
module tb_set_assoc;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        comp;
  logic        write;
  logic [1:0]  word;
  logic [0:0]  way_sel;
  logic [4:0]  tag_in;
  logic [15:0] data_in;
  logic        valid_in;
  logic        hit;
  logic [0:0]  hit_way;
  logic        valid_out;
  logic        dirty_out;
  logic [4:0]  tag_out;
  logic [15:0] data_out;
  logic        ack;
  logic [1:0]  dbg_state;
`ifdef SET_LRU_EN
  logic [0:0]  victim;
`endif

  int total = 0;
  int bad   = 0;
  int lat;
  int acks;
  logic [15:0] exp_q[$];

  set_assoc dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .comp      (comp),
    .write     (write),
    .word      (word),
    .way_sel   (way_sel),
    .tag_in    (tag_in),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .hit       (hit),
    .hit_way   (hit_way),
    .valid_out (valid_out),
    .dirty_out (dirty_out),
    .tag_out   (tag_out),
    .data_out  (data_out),
    .ack       (ack),
    .dbg_state (dbg_state)
`ifdef SET_LRU_EN
    ,
    .victim    (victim)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic chk_data(input string name);
    logic [15:0] e;
    e = exp_q.pop_front();
    chk(name, {16'h0, data_out}, {16'h0, e});
  endtask

  // One full operation: capture, scramble inputs while busy, wait for ack, release enable.
  task automatic run_op(input logic c, input logic w, input logic [1:0] wd, input logic ws,
                        input logic [4:0] tg, input logic [15:0] dt, input logic vl);
    int l;
    @(negedge clk);
    comp = c; write = w; word = wd; way_sel = ws;
    tag_in = tg; data_in = dt; valid_in = vl; enable = 1'b1;
    l = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        comp     = ~c;
        write    = ~w;
        word     = 2'($urandom_range(0, 3));
        way_sel  = ~ws;
        tag_in   = 5'($urandom_range(0, 31));
        data_in  = 16'($urandom_range(0, 65535));
        valid_in = ~vl;
      end
      if (ack) begin
        l = k;
        break;
      end
    end
    chk("ack_latency", l, 2);
    enable = 1'b0;
    @(negedge clk);
    chk("ack_one_cycle", {31'h0, ack}, 0);
    @(negedge clk);
    chk("back_to_idle", {30'h0, dbg_state}, 0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; comp = 1'b0; write = 1'b0; word = '0;
    way_sel = '0; tag_in = '0; data_in = '0; valid_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hit", {31'h0, hit}, 0);
    chk("rst_hit_way", {31'h0, hit_way}, 0);
    chk("rst_valid", {31'h0, valid_out}, 0);
    chk("rst_dirty", {31'h0, dirty_out}, 0);
    chk("rst_tag", {27'h0, tag_out}, 0);
    chk("rst_data", {16'h0, data_out}, 0);
    chk("rst_ack", {31'h0, ack}, 0);
    chk("rst_state", {30'h0, dbg_state}, 0);
    rst = 1'b0;

    // Install and read back way1/word2.
    run_op(1'b0, 1'b1, 2'd2, 1'b1, 5'h0A, 16'hBEEF, 1'b1);
    exp_q.push_back(16'hBEEF);
    run_op(1'b0, 1'b0, 2'd2, 1'b1, 5'h00, 16'h0000, 1'b0);
    chk_data("acc_rd_data");
    chk("acc_rd_tag", {27'h0, tag_out}, 32'h0A);
    chk("acc_rd_dirty", {31'h0, dirty_out}, 0);
    chk("acc_rd_valid", {31'h0, valid_out}, 1);
    chk("acc_rd_hit", {31'h0, hit}, 0);

    // Compare read hit, then miss (data_out must hold).
    exp_q.push_back(16'hBEEF);
    run_op(1'b1, 1'b0, 2'd2, 1'b0, 5'h0A, 16'h0000, 1'b0);
    chk("cmp_rd_hit", {31'h0, hit}, 1);
    chk("cmp_rd_hit_way", {31'h0, hit_way}, 1);
    chk_data("cmp_rd_data");
    exp_q.push_back(16'hBEEF);
    run_op(1'b1, 1'b0, 2'd2, 1'b0, 5'h0B, 16'h0000, 1'b0);
    chk("cmp_miss_hit", {31'h0, hit}, 0);
    chk("cmp_miss_hit_way", {31'h0, hit_way}, 0);
    chk("cmp_miss_valid_way0", {31'h0, valid_out}, 0);
    chk_data("cmp_miss_data_hold");

    // Compare write hit marks dirty; access read sees the new word.
    run_op(1'b1, 1'b1, 2'd2, 1'b0, 5'h0A, 16'h1234, 1'b0);
    chk("cmp_wr_hit", {31'h0, hit}, 1);
    chk("cmp_wr_dirty", {31'h0, dirty_out}, 1);
    exp_q.push_back(16'h1234);
    run_op(1'b0, 1'b0, 2'd2, 1'b1, 5'h00, 16'h0000, 1'b0);
    chk_data("after_cmp_wr_data");
    chk("after_cmp_wr_dirty", {31'h0, dirty_out}, 1);

    // Same tag in both ways resolves to way0; reinstalling word0 keeps word2.
    run_op(1'b0, 1'b1, 2'd1, 1'b0, 5'h0A, 16'h5555, 1'b1);
    exp_q.push_back(16'h5555);
    run_op(1'b1, 1'b0, 2'd1, 1'b1, 5'h0A, 16'h0000, 1'b0);
    chk("dup_tag_hit", {31'h0, hit}, 1);
    chk("dup_tag_lowest_way", {31'h0, hit_way}, 0);
    chk_data("dup_tag_data");
    run_op(1'b0, 1'b1, 2'd0, 1'b1, 5'h0A, 16'h7777, 1'b1);
    exp_q.push_back(16'h1234);
    run_op(1'b0, 1'b0, 2'd2, 1'b1, 5'h00, 16'h0000, 1'b0);
    chk_data("other_word_kept");
    chk("reinstall_clears_dirty", {31'h0, dirty_out}, 0);

    // Tag installed with valid=0 must not hit.
    run_op(1'b0, 1'b1, 2'd0, 1'b1, 5'h0C, 16'h1111, 1'b0);
    run_op(1'b1, 1'b0, 2'd0, 1'b0, 5'h0C, 16'h0000, 1'b0);
    chk("invalid_way_miss", {31'h0, hit}, 0);

    // Compare write miss writes nothing.
    run_op(1'b1, 1'b1, 2'd1, 1'b0, 5'h1F, 16'hDEAD, 1'b0);
    chk("cmp_wr_miss_hit", {31'h0, hit}, 0);
    exp_q.push_back(16'h5555);
    run_op(1'b0, 1'b0, 2'd1, 1'b0, 5'h00, 16'h0000, 1'b0);
    chk_data("cmp_wr_miss_no_write");

    // Enable held high for 6 cycles produces a single ack.
    @(negedge clk);
    comp = 1'b0; write = 1'b0; word = 2'd1; way_sel = 1'b0; enable = 1'b1;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack) acks++;
    end
    enable = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (ack) acks++;
    end
    chk("held_enable_one_ack", acks, 1);
    chk("held_enable_idle", {30'h0, dbg_state}, 0);

    // Reset during LOOKUP aborts the write and clears valids.
    @(negedge clk);
    comp = 1'b0; write = 1'b1; word = 2'd0; way_sel = 1'b0;
    tag_in = 5'h03; data_in = 16'hAAAA; valid_in = 1'b1; enable = 1'b1;
    @(negedge clk);
    chk("lookup_reached", {30'h0, dbg_state}, 1);
    rst = 1'b1; enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    acks = 0;
    if (ack) acks++;
    chk("rst_abort_data", {16'h0, data_out}, 0);
    repeat (3) begin
      @(negedge clk);
      if (ack) acks++;
    end
    chk("rst_abort_no_ack", acks, 0);
    run_op(1'b1, 1'b0, 2'd0, 1'b0, 5'h03, 16'h0000, 1'b0);
    chk("rst_abort_miss", {31'h0, hit}, 0);
    run_op(1'b1, 1'b0, 2'd2, 1'b0, 5'h0A, 16'h0000, 1'b0);
    chk("rst_clears_valid", {31'h0, hit}, 0);

`ifdef SET_LRU_EN
    chk("victim_invalid_lowest", {31'h0, victim}, 0);
    run_op(1'b0, 1'b1, 2'd0, 1'b0, 5'h01, 16'h0101, 1'b1);
    chk("victim_way1_invalid", {31'h0, victim}, 1);
    run_op(1'b0, 1'b1, 2'd0, 1'b1, 5'h02, 16'h0202, 1'b1);
    run_op(1'b1, 1'b0, 2'd0, 1'b0, 5'h01, 16'h0000, 1'b0);
    chk("lru_hit_way0", {31'h0, hit}, 1);
    chk("lru_victim", {31'h0, victim}, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
